ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
Round-robin arbiter sharing one AHB address/data bus among NUM_MASTERS masters in the multi-master fabric that feeds the slave interface. Samples per-master HBUSREQ/HLOCK and the shared HTRANS/HBURST/HREADY. Drives registered one-hot HGRANT, plus the HMASTER and HMASTLOCK seen by slaves. Handover is legal only at burst boundaries, never during a locked sequence, and parks on a default master when idle.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
HMASTER_WIDTH, 4, width of HMASTER; must satisfy 2**HMASTER_WIDTH >= NUM_MASTERS
DEFAULT_MASTER, 0, parking master index when no request is pending

Ports:
hclk  input  1  bus clock; all state updates on rising edge
hreset  input  1  asynchronous, active-high reset
HBUSREQ  input  NUM_MASTERS  per-master bus request
HLOCK  input  NUM_MASTERS  per-master locked-transfer request
HTRANS  input  2  shared bus transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HBURST  input  3  shared bus burst type
HREADY  input  1  shared bus ready, as seen by masters
HGRANT  output  NUM_MASTERS  one-hot bus grant
HMASTER  output  HMASTER_WIDTH  index of the master owning the current address phase
HMASTLOCK  output  1  current address phase is locked

Behaviour:
- Clock/reset: one clock, hclk. Reset hreset is asynchronous, active-high.
- Reset values: HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, beat counter = 0, rr pointer = DEFAULT_MASTER.
- Reset mid-burst returns every output to its reset value immediately. No pending state survives reset.
- Beat counter (5 bits), updated only on cycles with HREADY=1:
  - NONSEQ with HBURST WRAP4/INCR4: load 3.
  - NONSEQ with WRAP8/INCR8: load 7.
  - NONSEQ with WRAP16/INCR16: load 15.
  - NONSEQ with SINGLE or INCR: load 0.
  - SEQ with count > 0: decrement.
  - IDLE: clear to 0 (early termination).
  - BUSY: hold.
- arb_ok = HREADY & ~lock_hold & (count==0 | (count==1 & HTRANS==SEQ)).
  - Handover therefore occurs when the final beat's address is accepted.
  - An undefined-length INCR may be rearbitrated on any HREADY cycle.
- lock_hold = HLOCK[owner] | HMASTLOCK, where owner is the index of the HGRANT bit.
  - Grant is held through the locked sequence plus the following address phase.
- Arbitration, evaluated combinationally and registered into HGRANT on the edge where arb_ok=1:
  - Search HBUSREQ round-robin starting at (rr pointer + 1) mod NUM_MASTERS, wrapping.
  - First requester wins. rr pointer takes the winner's index.
  - Current owner still requesting with no other requester: keeps grant.
  - No requester: grant DEFAULT_MASTER; rr pointer unchanged.
- arb_ok=0: HGRANT holds. HBUSREQ deassertion by the owner mid-burst has no effect until arb_ok.
- HMASTER and HMASTLOCK, on the edge where HREADY=1:
  - HMASTER <= owner index.
  - HMASTLOCK <= HLOCK[owner] & (HTRANS != IDLE on the following phase).
  - Implementation: register HLOCK[owner] alongside HMASTER.
  - With HREADY=0, both hold (wait states extend the phase).
- Latency: request to HGRANT is 1 cycle when arb_ok; HGRANT to HMASTER is 1 HREADY cycle.
- HGRANT is always exactly one-hot; verify by assertion.
- Indices >= NUM_MASTERS never appear on HMASTER.
- Simultaneous HLOCK and a higher-rr-priority request: lock wins.

Test Plan:
1. Reset with all HBUSREQ=0 -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0. Release reset, idle 5 cycles -> unchanged (parked).
2. HBUSREQ=4'b0110 held, SINGLE NONSEQ each HREADY cycle -> HGRANT alternates 0010, 0100, 0010. HMASTER follows one HREADY cycle later.
3. M1 granted issues INCR4 (NONSEQ + 3 SEQ) while M2 requests; insert 2 cycles of HREADY=0 on beat 2 -> HGRANT stays 0010 until the edge accepting beat 4, then 0100.
4. M3 issues WRAP8 then drives IDLE after beat 3 with M0 requesting -> counter clears and HGRANT moves to 0001 on the next HREADY edge.
5. M2 asserts HLOCK with 2 locked SINGLE transfers while M0/M1 request -> HGRANT held at 0100. HMASTLOCK=1 for both phases. Grant released 1 phase after HLOCK drops.
6. Assert hreset during beat 2 of M1's INCR16 -> outputs asynchronously return to HGRANT=0001, HMASTER=0, HMASTLOCK=0. After release, arbitration restarts from DEFAULT_MASTER.

Source files
------------

// File: rtl/ahb_bus_arbiter_if.sv
// Shared AHB arbitration signals: per-master requests/locks, the shared transfer
// controls, and the grant/ownership outputs seen by masters and slaves.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS   = 4,
  parameter int HMASTER_WIDTH = 4
);
  logic [NUM_MASTERS-1:0]   HBUSREQ;
  logic [NUM_MASTERS-1:0]   HLOCK;
  logic [1:0]               HTRANS;
  logic [2:0]               HBURST;
  logic                     HREADY;
  logic [NUM_MASTERS-1:0]   HGRANT;
  logic [HMASTER_WIDTH-1:0] HMASTER;
  logic                     HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter: hands the bus over only at burst boundaries,
// never inside a locked sequence, and parks on DEFAULT_MASTER when idle.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int HMASTER_WIDTH  = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input logic              hclk,
  input logic              hreset,
  ahb_bus_arbiter_if.slave bus
);
  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;
  localparam logic [HMASTER_WIDTH-1:0] DEFAULT_IDX = HMASTER_WIDTH'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]   DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [HMASTER_WIDTH:0]   NUM_WIDE = (HMASTER_WIDTH + 1)'(NUM_MASTERS);
  localparam logic [HMASTER_WIDTH:0]   ONE_WIDE = (HMASTER_WIDTH + 1)'(1);

  logic [NUM_MASTERS-1:0]   grant_reg, grant_next;
  logic [HMASTER_WIDTH-1:0] rr_reg, rr_next;
  logic [HMASTER_WIDTH-1:0] hmaster_reg;
  logic                     lock_reg;
  logic [4:0]               count_reg, count_next;

  logic [HMASTER_WIDTH-1:0] owner_term [NUM_MASTERS];
  logic [HMASTER_WIDTH-1:0] owner_idx;
  logic                     owner_lock, mastlock, lock_hold;
  logic                     burst_start, arb_ok, any_req;
  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic [HMASTER_WIDTH-1:0] rot_off, winner_idx;
  logic [HMASTER_WIDTH:0]   win_sum;

  genvar gi;
  for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_owner
    assign owner_term[gi] = grant_reg[gi] ? HMASTER_WIDTH'(gi) : '0;
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) owner_idx = owner_idx | owner_term[i];
  end

  assign owner_lock = |(bus.HLOCK & grant_reg);
  assign mastlock   = lock_reg & (bus.HTRANS != TRANS_IDLE);
  assign lock_hold  = owner_lock | mastlock;

  // The NONSEQ that opens a fixed-length burst is not a handover point even
  // though the counter still reads zero; the load takes effect on this edge.
  assign burst_start = (bus.HTRANS == TRANS_NONSEQ) && (bus.HBURST[2:1] != 2'b00);
  assign arb_ok = bus.HREADY & ~lock_hold &
                  (((count_reg == 5'd0) & ~burst_start) |
                   ((count_reg == 5'd1) & (bus.HTRANS == TRANS_SEQ)));

  // Rotate requests so bit 0 is the master just after the rr pointer.
  assign any_req = |bus.HBUSREQ;
  assign req_dbl = {bus.HBUSREQ, bus.HBUSREQ} >> ({1'b0, rr_reg} + ONE_WIDE);
  assign req_rot = req_dbl[NUM_MASTERS-1:0];

  always_comb begin
    rot_off = '0;
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (req_rot[j]) rot_off = HMASTER_WIDTH'(j);
    end
  end

  assign win_sum    = {1'b0, rr_reg} + {1'b0, rot_off} + ONE_WIDE;
  assign winner_idx = (win_sum >= NUM_WIDE) ? HMASTER_WIDTH'(win_sum - NUM_WIDE)
                                            : HMASTER_WIDTH'(win_sum);

  always_comb begin
    grant_next = grant_reg;
    rr_next    = rr_reg;
    if (arb_ok) begin
      if (any_req) begin
        grant_next = NUM_MASTERS'(1) << winner_idx;
        rr_next    = winner_idx;
      end else begin
        grant_next = DEFAULT_GRANT;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (bus.HREADY) begin
      case (bus.HTRANS)
        TRANS_NONSEQ: begin
          case (bus.HBURST)
            3'd2, 3'd3: count_next = 5'd3;
            3'd4, 3'd5: count_next = 5'd7;
            3'd6, 3'd7: count_next = 5'd15;
            default:    count_next = 5'd0;
          endcase
        end
        TRANS_SEQ:  if (count_reg != 5'd0) count_next = count_reg - 5'd1;
        TRANS_IDLE: count_next = 5'd0;
        default:    count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      grant_reg   <= DEFAULT_GRANT;
      rr_reg      <= DEFAULT_IDX;
      hmaster_reg <= DEFAULT_IDX;
      lock_reg    <= 1'b0;
      count_reg   <= 5'd0;
    end else begin
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
      count_reg <= count_next;
      // Wait states stretch the address phase, so ownership only advances on HREADY.
      if (bus.HREADY) begin
        hmaster_reg <= owner_idx;
        lock_reg    <= owner_lock;
      end
    end
  end

  assign bus.HGRANT    = grant_reg;
  assign bus.HMASTER   = hmaster_reg;
  assign bus.HMASTLOCK = mastlock;

  grant_onehot_a: assert property (@(posedge hclk) disable iff (hreset) $onehot(grant_reg));
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for the AHB arbiter: parking, round-robin, burst handover,
// early termination, locked sequences and asynchronous reset mid-burst.
module tb_ahb_bus_arbiter;
  localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, WRAP8 = 3'd4, INCR16 = 3'd7;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  ahb_bus_arbiter_if #(.NUM_MASTERS(4), .HMASTER_WIDTH(4)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS(4),
    .HMASTER_WIDTH(4),
    .DEFAULT_MASTER(0)
  ) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic ready);
    bus.HBUSREQ = req;
    bus.HLOCK   = lock;
    bus.HTRANS  = trans;
    bus.HBURST  = burst;
    bus.HREADY  = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic expect_bus(input string tag, input logic [3:0] gnt, input logic [3:0] mst,
                            input logic mlock);
    $display("%s: HGRANT=%b HMASTER=%0d HMASTLOCK=%b", tag, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK);
    check({tag, "/gnt"}, 32'(bus.HGRANT), 32'(gnt));
    check({tag, "/mst"}, 32'(bus.HMASTER), 32'(mst));
    check({tag, "/lock"}, 32'(bus.HMASTLOCK), 32'(mlock));
    check({tag, "/onehot"}, 32'($onehot(bus.HGRANT)), 32'd1);
  endtask

  initial begin
    // 1: reset and park
    drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
    tick();
    tick();
    expect_bus("reset", 4'b0001, 4'd0, 1'b0);
    hreset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    expect_bus("parked", 4'b0001, 4'd0, 1'b0);

    // 2: round-robin between M1 and M2 with single transfers
    drive(4'b0110, 4'b0000, NONSEQ, SINGLE, 1'b1);
    tick(); expect_bus("rr_a", 4'b0010, 4'd0, 1'b0);
    tick(); expect_bus("rr_b", 4'b0100, 4'd1, 1'b0);
    tick(); expect_bus("rr_c", 4'b0010, 4'd2, 1'b0);

    // 3: M1 INCR4 with two wait states on beat 2, M2 waiting
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); expect_bus("incr4_own", 4'b0010, 4'd1, 1'b0);
    drive(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1);
    tick(); expect_bus("incr4_b1", 4'b0010, 4'd1, 1'b0);
    drive(4'b0110, 4'b0000, SEQ, INCR4, 1'b0);
    tick(); expect_bus("incr4_ws1", 4'b0010, 4'd1, 1'b0);
    tick(); expect_bus("incr4_ws2", 4'b0010, 4'd1, 1'b0);
    drive(4'b0110, 4'b0000, SEQ, INCR4, 1'b1);
    tick(); expect_bus("incr4_b2", 4'b0010, 4'd1, 1'b0);
    tick(); expect_bus("incr4_b3", 4'b0010, 4'd1, 1'b0);
    tick(); expect_bus("incr4_b4", 4'b0100, 4'd1, 1'b0);

    // 4: M3 WRAP8 terminated early by IDLE after beat 3, M0 waiting
    drive(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); expect_bus("wrap8_gnt", 4'b1000, 4'd2, 1'b0);
    tick(); expect_bus("wrap8_own", 4'b1000, 4'd3, 1'b0);
    drive(4'b1001, 4'b0000, NONSEQ, WRAP8, 1'b1);
    tick(); expect_bus("wrap8_b1", 4'b1000, 4'd3, 1'b0);
    drive(4'b1001, 4'b0000, SEQ, WRAP8, 1'b1);
    tick(); expect_bus("wrap8_b2", 4'b1000, 4'd3, 1'b0);
    tick(); expect_bus("wrap8_b3", 4'b1000, 4'd3, 1'b0);
    drive(4'b1001, 4'b0000, IDLE, WRAP8, 1'b1);
    tick(); expect_bus("wrap8_idle", 4'b1000, 4'd3, 1'b0);
    tick(); expect_bus("wrap8_handover", 4'b0001, 4'd3, 1'b0);

    // 5: M2 locked pair of singles while M0/M1 request
    drive(4'b0100, 4'b0100, IDLE, SINGLE, 1'b1);
    tick(); expect_bus("lock_gnt", 4'b0100, 4'd0, 1'b0);
    drive(4'b0111, 4'b0100, IDLE, SINGLE, 1'b1);
    tick(); expect_bus("lock_own", 4'b0100, 4'd2, 1'b0);
    drive(4'b0111, 4'b0100, NONSEQ, SINGLE, 1'b1);
    expect_bus("lock_ph1", 4'b0100, 4'd2, 1'b1);
    tick();
    drive(4'b0111, 4'b0000, NONSEQ, SINGLE, 1'b1);
    expect_bus("lock_ph2", 4'b0100, 4'd2, 1'b1);
    tick();
    drive(4'b0111, 4'b0000, IDLE, SINGLE, 1'b1);
    expect_bus("lock_tail", 4'b0100, 4'd2, 1'b0);
    tick(); expect_bus("lock_release", 4'b0001, 4'd2, 1'b0);

    // 6: asynchronous reset during beat 2 of M1 INCR16
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); expect_bus("incr16_gnt", 4'b0010, 4'd0, 1'b0);
    tick(); expect_bus("incr16_own", 4'b0010, 4'd1, 1'b0);
    drive(4'b0011, 4'b0000, NONSEQ, INCR16, 1'b1);
    tick(); expect_bus("incr16_b1", 4'b0010, 4'd1, 1'b0);
    drive(4'b0011, 4'b0000, SEQ, INCR16, 1'b1);
    #2 hreset = 1'b1;
    #1 expect_bus("async_rst", 4'b0001, 4'd0, 1'b0);
    drive(4'b0110, 4'b0000, IDLE, SINGLE, 1'b1);
    tick();
    hreset = 1'b0;
    expect_bus("rst_hold", 4'b0001, 4'd0, 1'b0);
    tick(); expect_bus("restart_a", 4'b0010, 4'd0, 1'b0);
    tick(); expect_bus("restart_b", 4'b0100, 4'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
